// File: rtl/emit_pkg.sv
// Shared encodings for the emit sequencer: FSM state values and the datapath control codes
// driven on {cnt1_ld, cnt1_clr, cnt1_ACK}.
package emit_pkg;

  localparam logic [2:0] ENC_INIT  = 3'd0;
  localparam logic [2:0] ENC_IDLE  = 3'd1;
  localparam logic [2:0] ENC_LOAD  = 3'd2;
  localparam logic [2:0] ENC_EMIT  = 3'd3;
  localparam logic [2:0] ENC_STEP  = 3'd4;
  localparam logic [2:0] ENC_DONE  = 3'd5;
  localparam logic [2:0] ENC_ABORT = 3'd6;
  localparam logic [2:0] ENC_COOL  = 3'd7;

  typedef enum logic [2:0] {
    ST_INIT  = ENC_INIT,
    ST_IDLE  = ENC_IDLE,
    ST_LOAD  = ENC_LOAD,
    ST_EMIT  = ENC_EMIT,
    ST_STEP  = ENC_STEP,
    ST_DONE  = ENC_DONE,
    ST_ABORT = ENC_ABORT,
    ST_COOL  = ENC_COOL
  } state_t;

  localparam logic [2:0] CTL_HOLD = 3'b001;
  localparam logic [2:0] CTL_LOAD = 3'b100;
  localparam logic [2:0] CTL_DEC  = 3'b101;
  localparam logic [2:0] CTL_CLR  = 3'b010;

  localparam int unsigned WD_W = 12;

endpackage

// File: rtl/emit_ctrl_if.sv
// Front-end/datapath signal bundle of the emit sequencer; master is the FSM side,
// slave is the button/sensor front end plus the emit datapath.
interface emit_ctrl_if;

  logic start;
  logic hand_on;
  logic eq_0;
  logic cnt1_ld;
  logic cnt1_clr;
  logic cnt1_ACK;
  logic busy;
  logic done;
  logic abort;
  logic timeout;

  modport master (
    input  start, hand_on, eq_0,
    output cnt1_ld, cnt1_clr, cnt1_ACK, busy, done, abort, timeout
  );

  modport slave (
    output start, hand_on, eq_0,
    input  cnt1_ld, cnt1_clr, cnt1_ACK, busy, done, abort, timeout
  );

endinterface

// File: rtl/emit_tick_gen.sv
// Decrement pacing prescaler: counts enabled cycles, tc_o high at TICK_DIV-1.
// Zero latency on tc_o (decoded from the count register); clear wins over enable.
module emit_tick_gen #(
  parameter int unsigned           TICK_W   = 4,
  parameter logic [TICK_W-1:0]     TICK_DIV = 4'd10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TICK_W-1:0] ONE = 1;

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == (TICK_DIV - ONE));

endmodule

// File: rtl/emit_ctrl.sv
// Emit dose sequencer: Moore FSM driving the datapath control triple, first DEC TICK_DIV+1 cycles after LOAD.
// No backpressure; start is level-sampled in IDLE only. Optional watchdog under EMIT_CTRL_TIMEOUT_EN.
module emit_ctrl
  import emit_pkg::*;
#(
  parameter int unsigned       TICK_W   = 4,
  parameter logic [TICK_W-1:0] TICK_DIV = 4'd10,
  parameter logic [7:0]        COOL_CYC = 8'd20
`ifdef EMIT_CTRL_TIMEOUT_EN
  , parameter logic [WD_W-1:0] MAX_EMIT_CYC = 12'd1000
`endif
) (
  input  logic clk,
  input  logic rst,
  emit_ctrl_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cool_q;
  logic [7:0] cool_d;
  logic [2:0] ctl;
  logic       busy_c;
  logic       done_c;
  logic       abort_c;
  logic       tick_tc;
  logic       tick_clr;
  logic       tick_en;

  assign tick_clr = (state_q == ST_LOAD) || ((state_q == ST_EMIT) && tick_tc);
  assign tick_en  = (state_q == ST_EMIT);

  emit_tick_gen #(
    .TICK_W   (TICK_W),
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tick_clr),
    .en_i  (tick_en),
    .tc_o  (tick_tc)
  );

`ifdef EMIT_CTRL_TIMEOUT_EN
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            to_q;
  logic            to_d;
  logic            wd_hit;

  assign wd_hit = (wd_q >= MAX_EMIT_CYC);

  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_LOAD) begin
      wd_d = '0;
    end else if ((state_q == ST_EMIT) || (state_q == ST_STEP)) begin
      wd_d = wd_q + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    ctl     = CTL_HOLD;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    abort_c = 1'b0;
`ifdef EMIT_CTRL_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        ctl     = CTL_CLR;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy_c = 1'b0;
        if (bus.start && bus.hand_on) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ctl     = CTL_LOAD;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // Hand removal outranks everything, then the watchdog, then completion.
        if (!bus.hand_on) begin
          state_d = ST_ABORT;
`ifdef EMIT_CTRL_TIMEOUT_EN
        end else if (wd_hit) begin
          state_d = ST_ABORT;
          to_d    = 1'b1;
`endif
        end else if (bus.eq_0) begin
          state_d = ST_DONE;
        end else if (tick_tc) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        ctl     = CTL_DEC;
        state_d = ST_EMIT;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        cool_d  = 8'd0;
        state_d = ST_COOL;
      end
      ST_ABORT: begin
        ctl     = CTL_CLR;
        abort_c = 1'b1;
        cool_d  = 8'd0;
        state_d = ST_COOL;
      end
      ST_COOL: begin
        if (cool_q == (COOL_CYC - 8'd1)) begin
          state_d = ST_IDLE;
        end else begin
          cool_d = cool_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cool_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
    end
  end

  assign bus.cnt1_ld  = ctl[2];
  assign bus.cnt1_clr = ctl[1];
  assign bus.cnt1_ACK = ctl[0];
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.abort    = abort_c;

endmodule

// File: tb/tb_emit_ctrl.sv
// Directed bench for emit_ctrl with a behavioural emit datapath (load/dec/clear counter) closing the eq_0 loop.
// Build with EMIT_CTRL_TIMEOUT_EN to exercise the watchdog path (MAX_EMIT_CYC = 10).
module tb_emit_ctrl;
  import emit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_checks = 0;
  int         n_errs   = 0;
  logic [7:0] emit_cnt = 8'd5;
  logic [7:0] dp_cnt   = 8'd0;
  logic [2:0] e_ctl;
  logic [2:0] code;

  emit_ctrl_if bus ();

  emit_ctrl #(
    .TICK_W   (4),
    .TICK_DIV (4'd4),
    .COOL_CYC (8'd8)
`ifdef EMIT_CTRL_TIMEOUT_EN
    , .MAX_EMIT_CYC (12'd10)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign code     = {bus.cnt1_ld, bus.cnt1_clr, bus.cnt1_ACK};
  assign bus.eq_0 = (dp_cnt == 8'd0);

  always @(posedge clk) begin
    case (code)
      CTL_LOAD: dp_cnt <= emit_cnt;
      CTL_DEC:  dp_cnt <= dp_cnt - 8'd1;
      CTL_CLR:  dp_cnt <= 8'd0;
      default:  dp_cnt <= dp_cnt;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string pfx, input int c, input logic [2:0] ec,
                             input logic eb, input logic ed, input logic ea, input logic et);
    check_eq($sformatf("%s_ctl@%0d", pfx, c), int'(code), int'(ec));
    check_eq($sformatf("%s_busy@%0d", pfx, c), int'(bus.busy), int'(eb));
    check_eq($sformatf("%s_done@%0d", pfx, c), int'(bus.done), int'(ed));
    check_eq($sformatf("%s_abort@%0d", pfx, c), int'(bus.abort), int'(ea));
    check_eq($sformatf("%s_timeout@%0d", pfx, c), int'(bus.timeout), int'(et));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.hand_on = 1'b0;

    // Power-on reset: INIT drives CLR while rst is held and for one cycle after release.
    #1;
    check_cycle("rst_async", 0, CTL_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check_cycle("rst_init", 0, CTL_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_cycle("rst_idle", 0, CTL_HOLD, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_eq0", int'(bus.eq_0), 1);

`ifndef EMIT_CTRL_TIMEOUT_EN
    // Nominal five-count dose.
    emit_cnt    = 8'd5;
    bus.start   = 1'b1;
    bus.hand_on = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      step();
      e_ctl = CTL_HOLD;
      if (c == 1) e_ctl = CTL_LOAD;
      else if (c == 6 || c == 11 || c == 16 || c == 21 || c == 26) e_ctl = CTL_DEC;
      check_cycle("nom", c, e_ctl, c < 37, c == 28, 1'b0, 1'b0);
      if (c == 1) bus.start = 1'b0;
    end
`else
    // Watchdog expiry during a five-count dose: abort and timeout together, no done.
    emit_cnt    = 8'd5;
    bus.start   = 1'b1;
    bus.hand_on = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      step();
      e_ctl = CTL_HOLD;
      if (c == 1) e_ctl = CTL_LOAD;
      else if (c == 6 || c == 11) e_ctl = CTL_DEC;
      else if (c == 13) e_ctl = CTL_CLR;
      check_cycle("wdog", c, e_ctl, c < 22, 1'b0, c == 13, c == 13);
      if (c == 1) bus.start = 1'b0;
    end
`endif

    // Hand removed in EMIT at cycle 12.
    emit_cnt    = 8'd5;
    bus.start   = 1'b1;
    bus.hand_on = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      step();
      e_ctl = CTL_HOLD;
      if (c == 1) e_ctl = CTL_LOAD;
      else if (c == 6 || c == 11) e_ctl = CTL_DEC;
      else if (c == 13) e_ctl = CTL_CLR;
      check_cycle("hand", c, e_ctl, c < 22, 1'b0, c == 13, 1'b0);
      if (c == 14) check_eq("hand_dp_cleared", int'(dp_cnt), 0);
      if (c == 1) bus.start = 1'b0;
      if (c == 12) bus.hand_on = 1'b0;
    end

    // start without a hand in IDLE is ignored.
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_cycle("nohand", c, CTL_HOLD, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Zero-count doses back to back; start held through COOL must not relaunch early.
    emit_cnt    = 8'd0;
    bus.hand_on = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      e_ctl = (c == 1 || c == 13) ? CTL_LOAD : CTL_HOLD;
      check_cycle("zero", c, e_ctl, !(c == 12 || c >= 24), c == 3 || c == 15, 1'b0, 1'b0);
      if (c == 1) bus.start = 1'b0;
      if (c == 5) bus.start = 1'b1;
      if (c == 13) bus.start = 1'b0;
    end

`ifndef EMIT_CTRL_TIMEOUT_EN
    // Reset asserted mid-dose at cycle 15.
    emit_cnt    = 8'd5;
    bus.start   = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      e_ctl = CTL_HOLD;
      if (c == 1) e_ctl = CTL_LOAD;
      else if (c == 6 || c == 11) e_ctl = CTL_DEC;
      check_cycle("mid", c, e_ctl, 1'b1, 1'b0, 1'b0, 1'b0);
      if (c == 1) bus.start = 1'b0;
    end
    check_eq("mid_dp_before", int'(dp_cnt), 3);
    rst = 1'b1;
    #1;
    check_cycle("mid_rst_async", 0, CTL_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    check_cycle("mid_rst_init", 0, CTL_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_cycle("mid_rst_idle", 0, CTL_HOLD, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mid_eq0", int'(bus.eq_0), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
